// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, NDIG digits,
// double-buffered display value committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int DIV      = 50000,
  parameter int GUARD    = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value_in,
  input  logic              load,
  output logic              load_ack,
  output logic              frame_tick,
  output logic [3:0]        bcd,
  output logic [NDIG-1:0]   dig_en
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] pending_q, pending_d;
  logic              pend_q, pend_d;
  logic              load_ack_q, load_ack_d;
  logic              frame_tick_q, frame_tick_d;
  logic [3:0]        bcd_q, bcd_d;
  logic [NDIG-1:0]   dig_en_q, dig_en_d;

  logic              slot_end, frame_end;
  logic [3:0]        nib;
  logic [NDIG-1:0]   lz;
  logic              z;

  always_comb begin
    slot_end     = (cnt_q == CW'(DIV - 1));
    frame_end    = slot_end && (idx_q == IW'(NDIG - 1));
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IW'(1);

    active_d     = active_q;
    pending_d    = pending_q;
    pend_d       = pend_q;
    load_ack_d   = 1'b0;
    frame_tick_d = frame_end;
    if (frame_end && pend_q) begin
      active_d   = pending_q;
      pend_d     = 1'b0;
      load_ack_d = 1'b1;
    end
    // A load on the commit cycle re-arms pending for the following frame.
    if (load) begin
      pending_d = value_in;
      pend_d    = 1'b1;
    end

    // Outputs are computed from next-state so the registers line up with cnt/idx.
    z  = 1'b1;
    lz = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      z     = z && (active_d[4*i +: 4] == 4'd0);
      lz[i] = z;
    end
    nib = active_d[{idx_d, 2'b00} +: 4];
    if (nib > 4'd9)
      bcd_d = 4'hF;
    else if ((BLANK_LZ != 0) && (idx_d != '0) && lz[idx_d])
      bcd_d = 4'hF;
    else
      bcd_d = nib;

    if ((GUARD == 0) || (cnt_d >= CW'(GUARD)))
      dig_en_d = NDIG'(1) << idx_d;
    else
      dig_en_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      bcd_q        <= 4'hF;
      dig_en_q     <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
      bcd_q        <= bcd_d;
      dig_en_q     <= dig_en_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;
  assign bcd        = bcd_q;
  assign dig_en     = dig_en_q;
endmodule
